// File: rtl/boom_input_cond.sv
// Input conditioning for the bomb game core: 2-flop synchronisers, debounced
// sw7/start/btn6 levels with armed-gated press pulses, and a stable-commit code path.
module boom_input_cond #(
  parameter int DEB_CYCLES       = 2000,
  parameter int SW_STABLE_CYCLES = 2000,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw7_raw,
  input  logic       start_raw,
  input  logic       btn6_raw,
  input  logic [6:0] sw_raw,
  output logic       armed,
  output logic       start_pulse,
  output logic       submit_pulse,
  output logic [6:0] code,
  output logic       code_valid,
  output logic       code_changed
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_STABLE_CYCLES - 1);

  // Bit layout: [9]=sw7, [8]=start, [7]=btn6, [6:0]=code switches.
  logic [9:0] s1;
  logic [9:0] s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sw7_raw, start_raw, btn6_raw, sw_raw};
      s2 <= s1;
    end
  end

  // Key channels: index 2=sw7, 1=start, 0=btn6.
  logic [2:0]       key_s2;
  logic [2:0]       key_stable;
  logic [2:0]       key_accept;
  logic [2:0]       key_rise;
  logic [CNT_W-1:0] key_cnt [3];

  assign key_s2 = s2[9:7];

  always_comb begin
    key_accept = '0;
    key_rise   = '0;
    for (int i = 0; i < 3; i++) begin
      key_accept[i] = (key_s2[i] != key_stable[i]) && (key_cnt[i] == DEB_LAST);
      key_rise[i]   = key_accept[i] & key_s2[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_stable <= '0;
      for (int i = 0; i < 3; i++) key_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (key_s2[i] == key_stable[i]) begin
          key_cnt[i] <= '0;
        end else if (key_accept[i]) begin
          key_stable[i] <= key_s2[i];
          key_cnt[i]    <= '0;
        end else begin
          key_cnt[i] <= key_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign armed = key_stable[2];

  // Gating uses the armed level before this edge, so a key that settles in the
  // same cycle as sw7 is treated as held, not pressed. Start has priority.
  logic start_fire;
  logic submit_fire;

  assign start_fire  = key_rise[1] & armed;
  assign submit_fire = key_rise[0] & armed & ~start_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_pulse  <= 1'b0;
      submit_pulse <= 1'b0;
    end else begin
      start_pulse  <= start_fire;
      submit_pulse <= submit_fire;
    end
  end

  logic [6:0]       sw_s2;
  logic [6:0]       sw_prev;
  logic [CNT_W-1:0] vec_cnt;
  logic             sw_same;
  logic             commit;

  assign sw_s2   = s2[6:0];
  assign sw_same = (sw_s2 == sw_prev);
  assign commit  = sw_same && (vec_cnt == SW_LAST) && (sw_s2 != code);

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_prev      <= '0;
      vec_cnt      <= '0;
      code         <= '0;
      code_changed <= 1'b0;
    end else begin
      sw_prev      <= sw_s2;
      code_changed <= commit;
      if (!sw_same) begin
        vec_cnt <= '0;
      end else if (vec_cnt != SW_LAST) begin
        vec_cnt <= vec_cnt + CNT_W'(1);
      end
      if (commit) begin
        code <= sw_s2;
      end
    end
  end

  assign code_valid = (code != '0);

endmodule

// File: tb/tb_boom_input_cond.sv
// Bench for boom_input_cond: directed sequences, a code-path vector table and a
// randomized phase checked every cycle against a run-length reference model.
module tb_boom_input_cond;

  localparam int D  = 2000;
  localparam int SW = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw7_raw;
  logic       start_raw;
  logic       btn6_raw;
  logic [6:0] sw_raw;
  logic       armed;
  logic       start_pulse;
  logic       submit_pulse;
  logic [6:0] code;
  logic       code_valid;
  logic       code_changed;

  boom_input_cond #(
    .DEB_CYCLES(D),
    .SW_STABLE_CYCLES(SW),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw7_raw(sw7_raw),
    .start_raw(start_raw),
    .btn6_raw(btn6_raw),
    .sw_raw(sw_raw),
    .armed(armed),
    .start_pulse(start_pulse),
    .submit_pulse(submit_pulse),
    .code(code),
    .code_valid(code_valid),
    .code_changed(code_changed)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_start = 0;
  int n_sub = 0;
  int n_chg = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // s2 is the raw value two edges old; a key level is accepted once s2 has
  // disagreed with it for D consecutive edges; the code commits once s2 has
  // matched its previous sample on SW consecutive edges.
  logic [9:0] m_s1, m_s2;
  logic [2:0] m_stab;
  int         m_run [3];
  logic [6:0] m_prev, m_code;
  int         m_eq;
  logic       m_sp, m_sbp, m_chg;
  logic [2:0] m_rose;
  logic       m_armed_old;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stab = '0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
      m_prev = '0; m_code = '0; m_eq = 0;
      m_sp = 1'b0; m_sbp = 1'b0; m_chg = 1'b0;
    end else begin
      m_armed_old = m_stab[2];
      m_rose = '0;
      for (int c = 0; c < 3; c++) begin
        if (m_s2[7+c] != m_stab[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_stab[c] = m_s2[7+c];
            m_run[c]  = 0;
            m_rose[c] = m_stab[c];
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_sp  = m_rose[1] & m_armed_old;
      m_sbp = m_rose[0] & m_armed_old & ~m_sp;
      m_chg = 1'b0;
      if (m_s2[6:0] == m_prev) begin
        if (m_eq < SW) m_eq++;
      end else begin
        m_eq = 0;
      end
      if (m_eq >= SW && m_s2[6:0] != m_code) begin
        m_code = m_s2[6:0];
        m_chg  = 1'b1;
      end
      m_prev = m_s2[6:0];
      m_s2 = m_s1;
      m_s1 = {sw7_raw, start_raw, btn6_raw, sw_raw};
    end
  end

  // ---------------- scoreboard: per-cycle model compare + pulse counters ----------------
  logic [11:0] dut_vec, mdl_vec;
  assign dut_vec = {armed, start_pulse, submit_pulse, code, code_valid, code_changed};
  assign mdl_vec = {m_stab[2], m_sp, m_sbp, m_code, (m_code != 7'd0), m_chg};

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (dut_vec !== mdl_vec) begin
        n_err++;
        $display("FAIL model_cycle t=%0t: got %b expected %b", $time, dut_vec, mdl_vec);
      end
    end
    if (start_pulse === 1'b1) n_start++;
    if (submit_pulse === 1'b1) n_sub++;
    if (code_changed === 1'b1) n_chg++;
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- code-path vector table ----------------
  typedef struct {
    logic [6:0] val_a;
    logic [6:0] val_b;
    int         period;
    int         reps;
    logic [6:0] exp_code;
    logic       exp_valid;
    int         exp_changes;
    int         exp_lat;
  } code_vec_t;

  code_vec_t tbl [5];
  int lat;
  int cyc;

  initial begin
    tbl[0] = '{7'b1010110, 7'b1010110, 2500, 1, 7'b1010110, 1'b1, 1, SW + 3};
    tbl[1] = '{7'b0000000, 7'b0000000, 2500, 1, 7'b0000000, 1'b0, 1, SW + 3};
    tbl[2] = '{7'h55,      7'h2a,      1000, 5, 7'b0000000, 1'b0, 0, 0};
    tbl[3] = '{7'h7f,      7'h7f,      2500, 1, 7'h7f,      1'b1, 1, SW + 3};
    tbl[4] = '{7'h7f,      7'h7f,      2500, 1, 7'h7f,      1'b1, 0, 0};

    // Reset with every raw input high.
    rst = 1'b1; sw7_raw = 1'b1; start_raw = 1'b1; btn6_raw = 1'b1; sw_raw = 7'h7f;
    tick(3);
    check("rst_armed", armed, 0);
    check("rst_start_pulse", start_pulse, 0);
    check("rst_submit_pulse", submit_pulse, 0);
    check("rst_code", code, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_code_changed", code_changed, 0);
    chk_en = 1'b1;
    n_start = 0; n_sub = 0;
    rst = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (armed !== 1'b1 && lat < 3 * D);
    check("arm_latency", lat, D + 2);
    tick(100);
    check("held_keys_start_pulses", n_start, 0);
    check("held_keys_submit_pulses", n_sub, 0);

    // Armed start press: one pulse, none on release.
    start_raw = 1'b0; btn6_raw = 1'b0;
    tick(D + 10);
    n_start = 0; n_sub = 0;
    start_raw = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (start_pulse !== 1'b1 && lat < 3 * D);
    check("start_latency", lat, D + 2);
    tick(6000 - lat);
    start_raw = 1'b0;
    tick(2100);
    check("start_pulse_count", n_start, 1);
    check("start_no_submit", n_sub, 0);

    // Bounce filtering on btn6.
    n_sub = 0;
    btn6_raw = 1'b1; tick(6000);
    btn6_raw = 1'b0; tick(500);
    btn6_raw = 1'b1; tick(6000);
    btn6_raw = 1'b0; tick(2100);
    check("bounce_submit_count", n_sub, 1);
    n_sub = 0;
    btn6_raw = 1'b1; tick(D - 1);
    btn6_raw = 1'b0; tick(2100);
    check("glitch_submit_count", n_sub, 0);

    // Disarmed gating, no queued press after arming.
    sw7_raw = 1'b0; tick(D + 10);
    check("disarm_armed", armed, 0);
    n_sub = 0;
    btn6_raw = 1'b1; tick(6000);
    check("disarmed_submit_count", n_sub, 0);
    sw7_raw = 1'b1; tick(D + 10);
    check("rearm_armed", armed, 1);
    check("rearm_no_queued_submit", n_sub, 0);
    btn6_raw = 1'b0; tick(D + 10);

    // Code path, table driven.
    for (int i = 0; i < 5; i++) begin
      n_chg = 0; lat = 0; cyc = 0;
      for (int r = 0; r < tbl[i].reps; r++) begin
        sw_raw = (r % 2 == 0) ? tbl[i].val_a : tbl[i].val_b;
        for (int k = 0; k < tbl[i].period; k++) begin
          @(negedge clk);
          cyc++;
          if (code_changed === 1'b1 && lat == 0) lat = cyc;
        end
      end
      check($sformatf("code_vec%0d_code", i), code, tbl[i].exp_code);
      check($sformatf("code_vec%0d_valid", i), code_valid, tbl[i].exp_valid);
      check($sformatf("code_vec%0d_changes", i), n_chg, tbl[i].exp_changes);
      check($sformatf("code_vec%0d_latency", i), lat, tbl[i].exp_lat);
    end

    // Simultaneous start and btn6 while armed.
    n_start = 0; n_sub = 0;
    start_raw = 1'b1; btn6_raw = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (start_pulse !== 1'b1 && lat < 3 * D);
    check("simul_start_latency", lat, D + 2);
    check("simul_submit_same_cycle", submit_pulse, 0);
    tick(3000);
    start_raw = 1'b0; btn6_raw = 1'b0;
    tick(2100);
    check("simul_start_count", n_start, 1);
    check("simul_submit_count", n_sub, 0);

    // Reset in the middle of a counting press.
    n_start = 0;
    start_raw = 1'b1; tick(1000);
    rst = 1'b1; tick(2);
    check("midrst_armed", armed, 0);
    rst = 1'b0;
    tick(D + 100);
    check("midrst_rearmed", armed, 1);
    check("midrst_start_count", n_start, 0);
    start_raw = 1'b0; tick(D + 10);

    // Randomized phase: slow random toggles, occasional reset.
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 1499) == 0) sw7_raw = ~sw7_raw;
      if ($urandom_range(0, 1499) == 0) start_raw = ~start_raw;
      if ($urandom_range(0, 1499) == 0) btn6_raw = ~btn6_raw;
      if ($urandom_range(0, 1999) == 0) sw_raw = 7'($urandom_range(0, 127));
      rst = ($urandom_range(0, 3999) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boom_input_cond.md
Name: boom_input_cond

Overview:
Input-conditioning stage that sits directly upstream of the bomb game core. It takes the raw board inputs: power switch sw7, start key, submit key btn6, and the 7-bit code switches. It synchronises and debounces them, then delivers clean levels and single-cycle pulses. The game core consumes armed, start_pulse, submit_pulse and the committed code, so it never sees bounce or metastable samples.

Parameters:
DEB_CYCLES, 2000, cycles a key/sw7 level must stay stable before it is accepted (2 ms at 1 MHz clk)
SW_STABLE_CYCLES, 2000, cycles the whole 7-bit switch vector must stay unchanged before it is committed
CNT_W, 16, width of each debounce counter; must hold max(DEB_CYCLES, SW_STABLE_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sw7_raw  in  1  raw power/arm switch
start_raw  in  1  raw start key
btn6_raw  in  1  raw submit key
sw_raw  in  7  raw code switches
armed  out  1  debounced sw7 level
start_pulse  out  1  one-cycle pulse on accepted start press
submit_pulse  out  1  one-cycle pulse on accepted btn6 press
code  out  7  committed switch vector
code_valid  out  1  high while code != 0
code_changed  out  1  one-cycle pulse when code takes a new value

Behaviour:
- Reset (rst=1 at a clk edge): all sync flops, debounced levels, counters and outputs go to 0. Reset mid-count discards the count. Reset wins over any simultaneous input event.
- Synchronisation: each raw bit passes through a 2-flop synchroniser. Every later stage sees only the second flop (s2).
- Key/sw7 debouncer, one per channel (sw7, start, btn6):
  - Each channel has a stable level reg and a counter.
  - s2 == stable: counter cleared.
  - s2 != stable: counter increments.
  - Counter == DEB_CYCLES-1 while s2 still != stable: stable <= s2 and counter is cleared.
  - Net effect: a glitch shorter than DEB_CYCLES cycles is never accepted.
  - Latency: stable changes exactly DEB_CYCLES cycles after s2 first differs, i.e. DEB_CYCLES+2 edges after the raw change.
- armed = stable level of the sw7 channel.
- start_pulse / submit_pulse: high for exactly the one cycle in which that channel's stable level goes 0->1. There is no pulse on release.
  - Pulses are gated by armed: while armed=0 they stay 0, and no press is queued.
  - If start and btn6 qualify in the same cycle, start_pulse fires and that submit press is dropped.
- Code path:
  - The 7-bit s2 vector is compared each cycle with its previous-cycle value. Any bit change clears the vector counter.
  - Otherwise the counter increments, saturating at SW_STABLE_CYCLES-1.
  - When it reaches SW_STABLE_CYCLES-1 and s2 != code, code <= s2 and code_changed pulses for 1 cycle.
  - If s2 == code, no pulse is issued.
  - Code commits regardless of armed.
- code_valid is combinational from the committed code: (code != 0).
- Counters never wrap: the key counters clear on acceptance, and the vector counter saturates.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all raw inputs high -> all outputs 0. Release rst -> armed=1 at DEB_CYCLES+2 edges after release; start_pulse and submit_pulse stay 0, since keys are held rather than rising after arm.
- Arm then start: sw7_raw=1; after armed=1, start_raw high for 6000 cycles -> exactly one start_pulse, DEB_CYCLES+2 edges after the rise, and no pulse on release.
- Bounce filtering: btn6_raw high 6000, low 500, high 6000 cycles with DEB_CYCLES=2000 -> exactly one submit_pulse. The 500-cycle gap is filtered. A 1999-cycle high glitch yields no pulse.
- Disarmed gating: sw7_raw=0, press btn6 for 6000 cycles -> submit_pulse=0 throughout. Arm afterwards without a new press -> still no pulse.
- Code commit: sw_raw=7'b1010110, held -> code=7'b1010110, code_valid=1 and one code_changed pulse. Then sw_raw=7'b0000000 -> code=0, code_valid=0 and one code_changed pulse. Toggling sw_raw every 1000 cycles -> code unchanged.
- Simultaneous keys: start_raw and btn6_raw rise on the same edge while armed -> start_pulse=1 and submit_pulse=0 in that cycle, with no later submit_pulse. A reset asserted during a counting press -> no pulse.
